// File: rtl/ifu_pkg.sv
// Shared constants, flush FSM encoding and im_addr width helper for the IFU F/D stage.
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int          IM_WORDS_DEFAULT = 4096;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    FLUSH_IDLE = 1'b0,
    FLUSH_PEND = 1'b1
  } flush_state_e;

  function automatic int im_addr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ifu_fd_stage_fd_pipe_reg.sv
// D-stage register bank: pc_D, instr_D, valid_D, fetch_err_D; 1-cycle latency.
// Backpressure: load=0 holds every field; squash loads a NOP marked not-valid.
module fd_pipe_reg
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        squash,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        err_in,
  output logic [31:0] pc_D,
  output logic [31:0] instr_D,
  output logic        valid_D,
  output logic        fetch_err_D
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (load) begin
      pc_d = pc_in;
      // A squashed slot keeps its PC but never reports a fault.
      if (squash) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end else begin
        instr_d = instr_in;
        valid_d = ~err_in;
        err_d   = err_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pc_D        = pc_q;
  assign instr_D     = instr_q;
  assign valid_D     = valid_q;
  assign fetch_err_D = err_q;

endmodule

// File: rtl/ifu_fd_stage.sv
// Fetch PC, imem range check and F/D register; instr at pc_F reaches D one edge later.
// stall freezes F and D; a flush seen under stall is deferred to the first unstalled edge. Optional fetch_cnt: IFU_FETCH_CNT_EN.
module ifu_fd_stage
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int          IM_WORDS = IM_WORDS_DEFAULT,
  localparam int         IM_AW    = im_addr_width(IM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      npc,
  input  logic [31:0]      im_rdata,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      pc_F,
  output logic [31:0]      pc_D,
  output logic [31:0]      pc8_D,
  output logic [31:0]      instr_D,
  output logic             valid_D,
  output logic             fetch_err_D,
  output logic [31:0]      fetch_cnt
);

  logic [31:0]  pc_f_q, pc_f_d;
  flush_state_e flush_q, flush_d;
  logic [31:0]  im_off;
  logic [32:0]  im_end;
  logic         f_err;
  logic [31:0]  instr_f;
  logic         load;
  logic         squash;

  // End bound kept in 33 bits so a region touching 2^32 still compares correctly.
  assign im_end  = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);
  assign im_off  = pc_f_q - IM_BASE;
  assign im_addr = IM_AW'(im_off >> 2);
  assign f_err   = (pc_f_q[1:0] != 2'b00) | (pc_f_q < IM_BASE) | ({1'b0, pc_f_q} >= im_end);
  assign instr_f = f_err ? NOP_INSTR : im_rdata;

  assign load   = ~stall;
  assign squash = flush | (flush_q == FLUSH_PEND);

  always_comb begin
    pc_f_d  = stall ? pc_f_q : npc;
    flush_d = flush_q;
    case (flush_q)
      FLUSH_IDLE: if (flush && stall) flush_d = FLUSH_PEND;
      FLUSH_PEND: if (!stall) flush_d = FLUSH_IDLE;
      default:    flush_d = FLUSH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q  <= RESET_PC;
      flush_q <= FLUSH_IDLE;
    end else begin
      pc_f_q  <= pc_f_d;
      flush_q <= flush_d;
    end
  end

  fd_pipe_reg u_fd_pipe_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .squash      (squash),
    .pc_in       (pc_f_q),
    .instr_in    (instr_f),
    .err_in      (f_err),
    .pc_D        (pc_D),
    .instr_D     (instr_D),
    .valid_D     (valid_D),
    .fetch_err_D (fetch_err_D)
  );

  assign pc_F  = pc_f_q;
  assign pc8_D = pc_D + 32'd8;

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (load && !squash && !f_err) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) fetch_cnt_q <= 32'h0;
    else       fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = 32'h0;
`endif

endmodule

// File: doc/ifu_fd_stage.md
Name: ifu_fd_stage

Overview:
Fetch-side consumer of the next-PC value produced in F/D. Holds the architectural fetch PC (pc_F), drives the instruction-memory address, and registers the fetched word into the F/D pipeline register (pc_D, instr_D). It closes the loop by feeding pc_F and pc_D back to next-PC computation. It also handles stall hold and deferred flush of the D stage.

Parameters:
RESET_PC, 32'h0000_3000, value loaded into pc_F on reset
IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0
IM_WORDS, 4096, instruction-memory depth in 32-bit words

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall; freezes F and D registers
flush  in  1  request to squash the D-stage instruction
npc  in  32  next fetch PC from next-PC logic
im_rdata  in  32  combinational instruction-memory read data for im_addr
im_addr  out  log2(IM_WORDS)  word index = (pc_F - IM_BASE) >> 2
pc_F  out  32  current fetch PC
pc_D  out  32  PC of instruction held in D
pc8_D  out  32  pc_D + 8 (link address)
instr_D  out  32  instruction held in D
valid_D  out  1  D holds a real, non-squashed instruction
fetch_err_D  out  1  D instruction came from a misaligned or out-of-range PC
fetch_cnt  out  32  count of valid instructions moved into D

Behaviour:
- Reset (synchronous, priority over everything): pc_F=RESET_PC; pc_D=0; instr_D=32'h0 (NOP); valid_D=0; fetch_err_D=0; pending_flush=0; fetch_cnt=0.
- pc8_D is combinational: pc_D + 8, 32-bit wrap.
- Fetch check is combinational on pc_F. f_err = (pc_F[1:0]!=0) | (pc_F < IM_BASE) | (pc_F >= IM_BASE + 4*IM_WORDS).
  - im_addr is always driven from pc_F, including when f_err is set.
  - When f_err is set, the fetched word is replaced by NOP.
- Normal cycle (stall=0, no flush in effect):
  - pc_F<=npc.
  - pc_D<=pc_F.
  - instr_D<=(f_err ? 0 : im_rdata).
  - valid_D<=~f_err.
  - fetch_err_D<=f_err.
- Latency: the instruction at pc_F appears in D exactly one cycle later. npc takes effect on the next edge. No internal branch logic.
- Stall=1: pc_F, pc_D, instr_D, valid_D and fetch_err_D all hold.
- Flush handling, 2-state FSM on pending_flush: IDLE(0), PEND(1).
  - flush=1, stall=0: D loads NOP, valid_D=0, fetch_err_D=0, pc_D<=pc_F. pc_F still advances to npc. FSM stays IDLE.
  - flush=1, stall=1: D holds. FSM goes to PEND.
  - PEND, stall=1: stay PEND, D holds. A repeated flush has no further effect.
  - PEND, stall=0: D loads NOP exactly as for an immediate flush. pc_F advances. FSM returns to IDLE.
- npc is taken verbatim, with no alignment correction. A bad npc surfaces one cycle later as fetch_err_D=1 with valid_D=0.
- pc_F wraps modulo 2^32. This is not an error in itself; the range check still applies.
- Reset asserted while stalled or in PEND: reset wins and the FSM returns to IDLE.

Optional Feature:
- Macro: IFU_FETCH_CNT_EN.
- Defined: fetch_cnt increments by 1 on every edge where D loads with valid_D<=1 (not reset, not stalled, not flushed, no f_err). It wraps at 2^32.
- Undefined: the counter flop is not built and fetch_cnt is tied to 0. The port is always present.

Decomposition:
- Shared package ifu_pkg:
  - RESET_PC_DEFAULT, IM_BASE_DEFAULT, NOP_INSTR (32'h0).
  - Flush FSM state encoding FLUSH_IDLE/FLUSH_PEND.
  - Width helper for im_addr.
- One natural sub-module, fd_pipe_reg: the D-stage register bank (pc_D, instr_D, valid_D, fetch_err_D).
  - Inputs: load, squash, next values.
  - Top level keeps pc_F, the range check, the flush FSM and the counter.

Test Plan:
- Reset then 3 free-running cycles with npc=pc_F+4, im_rdata=32'h2402_0001:
  - pc_F sequence is 0x3000, 0x3004, 0x3008.
  - pc_D=0x3000 with valid_D=1 after the first edge.
  - pc8_D=0x3008.
- Stall for 2 cycles with npc=0x3040:
  - pc_F, pc_D and instr_D are unchanged throughout.
  - On stall release, pc_F becomes 0x3040 after one edge.
- flush with stall=0:
  - Next edge: instr_D=0, valid_D=0, pc_F advances.
  - fetch_cnt does not increment (IFU_FETCH_CNT_EN defined).
- flush pulsed for 1 cycle while stall=1, stall held 3 more cycles, then released:
  - D holds during the stall.
  - First unstalled edge: D loads NOP, valid_D=0.
  - Following edge: normal valid fetch.
- npc=0x3002 (misaligned), then npc=0x2FFC, then 0x3000+4*IM_WORDS:
  - Each gives fetch_err_D=1, valid_D=0, instr_D=0 one cycle after it becomes pc_F.
- reset asserted during stall=1 with FSM in PEND:
  - Next edge: pc_F=0x3000, valid_D=0, FSM in IDLE, fetch_cnt=0.
